// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// trace_pkg -- record headers, FSM encoding and trace-entry layout shared by
//              the trace_uart_tx debug tap and its FIFO.
// Revision: 1.0
// ============================================================================
package trace_pkg;

  localparam logic [7:0] REC_HDR_REG = 8'h52;
  localparam logic [7:0] REC_HDR_MEM = 8'h4D;
  localparam int         REC_BYTES   = 7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  // Entry = {rV, brAddr, brDataIn, mV, memAddr, memDataIn}; memAddr width is added by the user.
  localparam int ENTRY_FIXED_W = 1 + 5 + 32 + 1 + 32;

  typedef struct packed {
    logic        rv;
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_evt_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// trace_fifo -- synchronous FIFO, extra-bit pointers for full/empty.
//               A push into a full FIFO is accepted when a pop happens in the same cycle.
// Revision: 1.0
// ============================================================================
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/trace_uart_tx.sv
`default_nettype none
// ============================================================================
// trace_uart_tx -- captures core register/memory writes into a FIFO and sends
//                  them as 7-byte records on a UART line (8N1, or 8E1 when
//                  TRACE_PARITY_EN is defined).
// Revision: 1.0
// ============================================================================
module trace_uart_tx
  import trace_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        brWrite,
  input  logic [4:0]                  brAddr,
  input  logic [31:0]                 brDataIn,
  input  logic                        memWr,
  input  logic [MEM_ADDR_W-1:0]       memAddr,
  input  logic [31:0]                 memDataIn,
  output logic                        txd,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

  localparam int          c_ENTRY_W     = ENTRY_FIXED_W + MEM_ADDR_W;
  localparam logic [15:0] c_BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [2:0]  c_LAST_BYTE   = 3'(REC_BYTES - 1);

  logic [2:0]            r_state;
  logic                  r_txd;
  logic                  r_overflow;
  logic [15:0]           r_baud;
  logic [2:0]            r_bit;
  logic [2:0]            r_byte;
  logic [7:0]            r_shift;
  logic                  r_is_mem;
  logic                  r_mem_pending;
  logic [4:0]            r_reg_addr;
  logic [31:0]           r_reg_data;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [31:0]           r_mem_data;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic [c_ENTRY_W-1:0]  w_fifo_din;
  logic [c_ENTRY_W-1:0]  w_fifo_dout;
  reg_evt_t              w_reg_evt;
  logic                  w_mem_v;
  logic                  w_baud_done;
  logic [15:0]           w_mem_addr16;
  logic [7:0]            w_byte;

  assign w_push     = brWrite | memWr;
  assign w_pop      = (r_state == ST_LOAD);
  assign w_drop     = w_push & w_full & ~w_pop;
  assign w_fifo_din = {brWrite, brAddr, brDataIn, memWr, memAddr, memDataIn};

  trace_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifoCount)
  );

  assign w_reg_evt    = w_fifo_dout[c_ENTRY_W-1 -: $bits(reg_evt_t)];
  assign w_mem_v      = w_fifo_dout[MEM_ADDR_W+32];
  assign w_baud_done  = (r_baud == 16'd0);
  assign w_mem_addr16 = 16'(r_mem_addr);

  // Byte currently on the wire, chosen from the held entry by record type and index.
  always_comb begin
    w_byte = 8'h00;
    if (!r_is_mem) begin
      case (r_byte)
        3'd0:    w_byte = REC_HDR_REG;
        3'd1:    w_byte = 8'h00;
        3'd2:    w_byte = {3'b000, r_reg_addr};
        3'd3:    w_byte = r_reg_data[31:24];
        3'd4:    w_byte = r_reg_data[23:16];
        3'd5:    w_byte = r_reg_data[15:8];
        default: w_byte = r_reg_data[7:0];
      endcase
    end else begin
      case (r_byte)
        3'd0:    w_byte = REC_HDR_MEM;
        3'd1:    w_byte = w_mem_addr16[15:8];
        3'd2:    w_byte = w_mem_addr16[7:0];
        3'd3:    w_byte = r_mem_data[31:24];
        3'd4:    w_byte = r_mem_data[23:16];
        3'd5:    w_byte = r_mem_data[15:8];
        default: w_byte = r_mem_data[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_txd         <= 1'b1;
      r_overflow    <= 1'b0;
      r_baud        <= 16'd0;
      r_bit         <= 3'd0;
      r_byte        <= 3'd0;
      r_shift       <= 8'h00;
      r_is_mem      <= 1'b0;
      r_mem_pending <= 1'b0;
      r_reg_addr    <= 5'd0;
      r_reg_data    <= 32'd0;
      r_mem_addr    <= '0;
      r_mem_data    <= 32'd0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_reg_addr    <= w_reg_evt.addr;
          r_reg_data    <= w_reg_evt.data;
          r_mem_addr    <= w_fifo_dout[MEM_ADDR_W+31:32];
          r_mem_data    <= w_fifo_dout[31:0];
          r_is_mem      <= ~w_reg_evt.rv;
          r_mem_pending <= w_reg_evt.rv & w_mem_v;
          r_byte        <= 3'd0;
          r_baud        <= c_BAUD_RELOAD;
          r_txd         <= 1'b0;
          r_state       <= ST_START;
        end
        ST_START: begin
          if (w_baud_done) begin
            r_baud  <= c_BAUD_RELOAD;
            r_txd   <= w_byte[0];
            r_shift <= w_byte >> 1;
            r_bit   <= 3'd0;
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud <= c_BAUD_RELOAD;
            if (r_bit == 3'd7) begin
`ifdef TRACE_PARITY_EN
              r_txd   <= ^w_byte;
              r_state <= ST_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_txd   <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
`ifdef TRACE_PARITY_EN
        ST_PARITY: begin
          if (w_baud_done) begin
            r_baud  <= c_BAUD_RELOAD;
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_baud_done) begin
            r_baud <= c_BAUD_RELOAD;
            if (r_byte != c_LAST_BYTE) begin
              r_byte  <= r_byte + 3'd1;
              r_txd   <= 1'b0;
              r_state <= ST_START;
            end else if (r_mem_pending) begin
              // Second half of a dual entry: memory record follows without a FIFO pop.
              r_is_mem      <= 1'b1;
              r_mem_pending <= 1'b0;
              r_byte        <= 3'd0;
              r_txd         <= 1'b0;
              r_state       <= ST_START;
            end else if (!w_empty) begin
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign txd      = r_txd;
  assign overflow = r_overflow;
  assign busy     = (r_state != ST_IDLE) | (fifoCount != '0);

endmodule
`default_nettype wire

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Non-intrusive debug tap on the mips32 core's architectural write outputs.
  - Register writeback: brWrite, brAddr, brDataIn.
  - Data-memory store: memWr, memAddr, memDataIn.
- Captures each write event into a small FIFO.
- Serialises events as fixed-format byte records on a UART TX line, so a host can reconstruct the core's state trace.

Parameters:
- CLK_DIV, 434, clocks per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8, trace entries buffered; power of two, >= 2.
- MEM_ADDR_W, 14, width of memAddr.

Ports:
- clk  in  1  system clock, same domain as the core.
- rst  in  1  reset; asynchronous, active-low.
- brWrite  in  1  register-file write strobe.
- brAddr  in  5  destination register.
- brDataIn  in  32  writeback value.
- memWr  in  1  data-memory write strobe.
- memAddr  in  MEM_ADDR_W  store address.
- memDataIn  in  32  store data.
- txd  out  1  UART serial out; idles high.
- busy  out  1  high while a record is being shifted or the FIFO is non-empty.
- overflow  out  1  sticky: an event was dropped.
- fifoCount  out  $clog2(FIFO_DEPTH)+1  entries held.

Behaviour:
- Reset (rst low, asynchronous): txd=1, busy=0, overflow=0, fifoCount=0, FSM=IDLE, FIFO emptied. A frame in progress is aborted immediately; no partial byte resumes after reset release.
- Capture:
  - On each rising edge where brWrite|memWr, one FIFO entry is pushed: {rV, brAddr, brDataIn, mV, memAddr, memDataIn}, where rV=brWrite and mV=memWr.
  - At most one push per cycle; a simultaneous reg and mem event shares one entry.
- Push acceptance: accepted if fifoCount<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the entry is dropped and overflow is set to 1 until reset.
- Records, 7 bytes each, bytes sent in order listed:
  - Register record: 0x52, 0x00, {3'b0,brAddr}, then data[31:24], [23:16], [15:8], [7:0].
  - Memory record: 0x4D, {(16-MEM_ADDR_W)'b0, addr[MEM_ADDR_W-1:8]}, addr[7:0], then 4 data bytes MSB first.
  - An entry with both valid sends the register record first, then the memory record.
- Byte framing (8N1): start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLK_DIV clocks. A record is 70*CLK_DIV clocks.
- Bit timing: a down-counter reloaded at every bit boundary. The bit counter is 0..7 and the byte index is 0..6.
- FSM states and transitions:
  - IDLE: txd=1. If FIFO non-empty -> LOAD.
  - LOAD: 1 cycle; pops entry into the shift holding register; selects record (reg if rV, else mem) -> START.
  - START -> DATA after CLK_DIV clocks.
  - DATA -> STOP after 8 bits.
  - STOP: after CLK_DIV clocks:
    - If byte index<6: next byte -> START.
    - Else if the pending mem record of a dual entry is not yet sent: byte index=0 -> START.
    - Else if FIFO non-empty -> LOAD, otherwise -> IDLE.
- Latency: event sampled at edge k with FSM in IDLE and FIFO empty → LOAD during cycle k+1 → txd falls at edge k+2.
- busy = (FSM!=IDLE) | (fifoCount!=0).
- FIFO wrap-around uses pointer extra-bit full/empty detection. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro TRACE_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP in a PARITY state, held CLK_DIV clocks. Frame is 11 bits; record is 77*CLK_DIV clocks.
- Undefined: no PARITY state, 8N1 as above.

Decomposition:
- Package trace_pkg:
  - REC_HDR_REG=8'h52, REC_HDR_MEM=8'h4D, REC_BYTES=7.
  - FSM state encoding (IDLE, LOAD, START, DATA, PARITY, STOP).
  - Trace entry struct/width constant (1+5+32+1+MEM_ADDR_W+32).
- Sub-module trace_fifo: synchronous FIFO with async active-low reset, push/pop, full/empty, count.
- Baud counter and serializer stay in trace_uart_tx.

Test Plan:
- Reset: rst low mid-run → txd=1, busy=0, overflow=0, fifoCount=0 immediately; hold 5 cycles → no txd transitions.
- Single writeback (CLK_DIV=4): brWrite, brAddr=5, brDataIn=32'hDEADBEEF for 1 cycle → txd low at k+2; bytes 52 00 05 DE AD BE EF decoded; busy low after 280 clocks.
- Dual event: brWrite (r3, 32'h00000001) and memWr (addr 14'h1234, 32'hCAFEF00D) in one cycle → 52 00 03 00 00 00 01 then 4D 12 34 CA FE F0 0D; fifoCount peaks at 1.
- Overflow (FIFO_DEPTH=8): 10 consecutive brWrite cycles with data 0..9 → records for data 0..8 transmitted in order; data 9 dropped; overflow=1 from the 10th edge onward.
- Reset mid-byte: assert rst during DATA of byte 3 → txd=1 same cycle; after release with no new events, no frame emitted and fifoCount=0.
- TRACE_PARITY_EN defined: single writeback r5 / 32'hDEADBEEF → header 0x52 parity bit 1, byte 0x00 parity 0; record length 308 clocks at CLK_DIV=4.
